// File: rtl/na_ctrl_pkg.sv
// Shared definitions for the nucleic-acid reactor chip sequencer:
// state encoding, valve-vector layout, per-step open masks, pump phases.
package na_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_BEADS = 4'd1,
    ST_LOAD_CELLS = 4'd2,
    ST_LYSIS      = 4'd3,
    ST_MIX        = 4'd4,
    ST_CAPTURE    = 4'd5,
    ST_WASH       = 4'd6,
    ST_ELUTE      = 4'd7,
    ST_SETTLE     = 4'd8,
    ST_ABORT      = 4'd9,
    ST_DONE       = 4'd10
  } state_e;

  // Bit positions of the ten valve air lines inside a valve vector.
  localparam int unsigned V_LYSIS      = 0;
  localparam int unsigned V_WASH       = 1;
  localparam int unsigned V_ELUTE      = 2;
  localparam int unsigned V_HORIZ      = 3;
  localparam int unsigned V_VERTICAL   = 4;
  localparam int unsigned V_LOOP_EXIT  = 5;
  localparam int unsigned V_BEAD_VTL   = 6;
  localparam int unsigned V_BEAD_TRAP  = 7;
  localparam int unsigned V_COLLECTION = 8;
  localparam int unsigned V_WASTE      = 9;
  localparam int unsigned NUM_VALVES   = 10;

  typedef logic [NUM_VALVES-1:0] valve_vec_t;

  // Open masks: a 1 marks a valve that is vented (open) during the step.
  localparam valve_vec_t OPEN_LOAD_BEADS = valve_vec_t'(
    (1 << V_BEAD_VTL) | (1 << V_BEAD_TRAP) | (1 << V_WASTE));
  localparam valve_vec_t OPEN_LOAD_CELLS = valve_vec_t'(
    (1 << V_HORIZ) | (1 << V_VERTICAL));
  localparam valve_vec_t OPEN_LYSIS = valve_vec_t'(
    (1 << V_LYSIS) | (1 << V_VERTICAL));
  localparam valve_vec_t OPEN_MIX = '0;
  localparam valve_vec_t OPEN_CAPTURE = valve_vec_t'(
    (1 << V_LOOP_EXIT) | (1 << V_BEAD_TRAP) | (1 << V_WASTE));
  localparam valve_vec_t OPEN_WASH = valve_vec_t'(
    (1 << V_WASH) | (1 << V_VERTICAL) | (1 << V_LOOP_EXIT) |
    (1 << V_BEAD_TRAP) | (1 << V_WASTE));
  localparam valve_vec_t OPEN_ELUTE = valve_vec_t'(
    (1 << V_ELUTE) | (1 << V_VERTICAL) | (1 << V_LOOP_EXIT) |
    (1 << V_BEAD_TRAP) | (1 << V_COLLECTION));

  // Forward {pump1,pump2,pump3} phases; entry 0 is the rightmost field.
  localparam logic [5:0][2:0] PUMP_TABLE = {
    3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011
  };

  function automatic valve_vec_t open_mask(input state_e s);
    case (s)
      ST_LOAD_BEADS: open_mask = OPEN_LOAD_BEADS;
      ST_LOAD_CELLS: open_mask = OPEN_LOAD_CELLS;
      ST_LYSIS:      open_mask = OPEN_LYSIS;
      ST_MIX:        open_mask = OPEN_MIX;
      ST_CAPTURE:    open_mask = OPEN_CAPTURE;
      ST_WASH:       open_mask = OPEN_WASH;
      ST_ELUTE:      open_mask = OPEN_ELUTE;
      default:       open_mask = '0;
    endcase
  endfunction

  function automatic logic is_pumped(input state_e s);
    is_pumped = (s == ST_LYSIS) || (s == ST_MIX) ||
                (s == ST_CAPTURE) || (s == ST_ELUTE);
  endfunction

  // Protocol order; the step after ELUTE is the DONE handshake.
  function automatic state_e next_step(input state_e s);
    case (s)
      ST_LOAD_BEADS: next_step = ST_LOAD_CELLS;
      ST_LOAD_CELLS: next_step = ST_LYSIS;
      ST_LYSIS:      next_step = ST_MIX;
      ST_MIX:        next_step = ST_CAPTURE;
      ST_CAPTURE:    next_step = ST_WASH;
      ST_WASH:       next_step = ST_ELUTE;
      ST_ELUTE:      next_step = ST_DONE;
      default:       next_step = ST_IDLE;
    endcase
  endfunction

  // Reverse direction walks the same table backwards, starting at 010.
  function automatic logic [2:0] pump_pattern(input logic [2:0] phase,
                                              input logic dir);
    logic [2:0] idx;
    idx = dir ? (3'd5 - phase) : phase;
    pump_pattern = PUMP_TABLE[idx];
  endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// Three-phase peristaltic pump pattern generator. The enable input is the
// next-cycle enable, so the first phase appears on the same edge the
// sequencer enters a pumped step.
module peristaltic_phase_gen
  import na_ctrl_pkg::*;
#(
  parameter int unsigned PUMP_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       dir_i,
  output logic [2:0] pump_o,
  output logic       cycle_done_o
);

  localparam int unsigned DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

  logic             active_q, active_d;
  logic [2:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       pump_q, pump_d;

  // Phase advance: restart at phase 0 on a fresh enable, step every PUMP_DIV.
  always_comb begin
    active_d = enable_i;
    phase_d  = phase_q;
    div_d    = div_q;
    pump_d   = pump_q;
    if (!enable_i) begin
      phase_d = '0;
      div_d   = '0;
      pump_d  = '1;
    end else if (!active_q) begin
      phase_d = '0;
      div_d   = '0;
      pump_d  = pump_pattern(3'd0, dir_i);
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      phase_d = (phase_q == 3'd5) ? 3'd0 : (phase_q + 3'd1);
      pump_d  = pump_pattern(phase_d, dir_i);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Pattern state registers; pump lines idle closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      div_q    <= '0;
      pump_q   <= '1;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      pump_q   <= pump_d;
    end
  end

  assign pump_o       = pump_q;
  // Marks the last clock of a full six-phase cycle.
  assign cycle_done_o = active_q && (phase_q == 3'd5) && (div_q == DIV_LAST);

endmodule

// File: rtl/na_chip_sequencer.sv
// Protocol sequencer for the 10-lane nucleic-acid reactor chip: walks
// LOAD_BEADS..ELUTE with break-before-make SETTLE gaps and drives the
// valve and pump air lines (1 = pressurised = closed).
module na_chip_sequencer
  import na_ctrl_pkg::*;
#(
  parameter int unsigned PUMP_DIV     = 1000,
  parameter int unsigned SETTLE_TICKS = 500,
  parameter int unsigned LOAD_TICKS   = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pump_rev,
  input  logic [7:0] mix_cycles,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] step,
  output logic       lysis_ctl,
  output logic       wash_ctl,
  output logic       elute_ctl,
  output logic       horiz_ctl,
  output logic       vertical_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       waste_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3
);

  localparam int unsigned MAX_A     = (PUMP_DIV > SETTLE_TICKS) ? PUMP_DIV : SETTLE_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_A > LOAD_TICKS) ? MAX_A : LOAD_TICKS;
  localparam int unsigned TICK_W    = $clog2(MAX_TICKS) + 1;

  localparam logic [TICK_W-1:0] LOAD_LAST   = TICK_W'(LOAD_TICKS - 1);
  localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_TICKS - 1);
  localparam logic [TICK_W-1:0] SETTLE_END  = TICK_W'(SETTLE_TICKS);

  state_e            state_q, state_d;
  state_e            next_q, next_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [7:0]        mix_q, mix_d;
  logic              rev_q, rev_d;
  logic              aborted_d;
  valve_vec_t        valves_q;
  logic              busy_q, done_q, aborted_q;

  logic              busy_state;
  logic              pump_en;
  logic              pump_cycle_done;
  logic [2:0]        pump_w;

  assign busy_state = (state_q != ST_IDLE) && (state_q != ST_ABORT) &&
                      (state_q != ST_DONE);

  // Next-state logic. A pumped step with mix_cycles=0 is replaced by an
  // extra SETTLE interval so every step keeps its break-before-make gap.
  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    tick_d    = tick_q;
    cyc_d     = cyc_q;
    mix_d     = mix_q;
    rev_d     = rev_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mix_d   = mix_cycles;
          rev_d   = pump_rev;
          state_d = ST_LOAD_BEADS;
          tick_d  = '0;
          cyc_d   = '0;
        end
      end

      ST_LOAD_BEADS, ST_LOAD_CELLS, ST_WASH: begin
        if (tick_q == LOAD_LAST) begin
          state_d = ST_SETTLE;
          next_d  = next_step(state_q);
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_LYSIS, ST_MIX, ST_CAPTURE, ST_ELUTE: begin
        if (pump_cycle_done) begin
          if (cyc_q == (mix_q - 8'd1)) begin
            state_d = ST_SETTLE;
            next_d  = next_step(state_q);
            tick_d  = '0;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
      end

      ST_SETTLE: begin
        if (tick_q == SETTLE_LAST) begin
          tick_d = '0;
          cyc_d  = '0;
          if (is_pumped(next_q) && (mix_q == 8'd0)) begin
            next_d = next_step(next_q);
          end else begin
            state_d = next_q;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_ABORT: begin
        if (tick_q == SETTLE_END) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == SETTLE_LAST) begin
            aborted_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && busy_state) begin
      state_d = ST_ABORT;
      tick_d  = '0;
      cyc_d   = '0;
    end
  end

  assign pump_en = is_pumped(state_d);

  // State, counters and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      next_q    <= ST_IDLE;
      tick_q    <= '0;
      cyc_q     <= '0;
      mix_q     <= '0;
      rev_q     <= 1'b0;
      valves_q  <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      tick_q    <= tick_d;
      cyc_q     <= cyc_d;
      mix_q     <= mix_d;
      rev_q     <= rev_d;
      valves_q  <= ~open_mask(state_d);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      aborted_q <= aborted_d;
    end
  end

  peristaltic_phase_gen #(
    .PUMP_DIV(PUMP_DIV)
  ) u_pump (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (pump_en),
    .dir_i        (rev_q),
    .pump_o       (pump_w),
    .cycle_done_o (pump_cycle_done)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign step           = state_q;
  assign lysis_ctl      = valves_q[V_LYSIS];
  assign wash_ctl       = valves_q[V_WASH];
  assign elute_ctl      = valves_q[V_ELUTE];
  assign horiz_ctl      = valves_q[V_HORIZ];
  assign vertical_ctl   = valves_q[V_VERTICAL];
  assign loop_exit_ctl  = valves_q[V_LOOP_EXIT];
  assign bead_vtl_ctl   = valves_q[V_BEAD_VTL];
  assign bead_trap_ctl  = valves_q[V_BEAD_TRAP];
  assign collection_ctl = valves_q[V_COLLECTION];
  assign waste_ctl      = valves_q[V_WASTE];
  assign pump1          = pump_w[2];
  assign pump2          = pump_w[1];
  assign pump3          = pump_w[0];

endmodule

// File: tb/tb_na_chip_sequencer.sv
// Scoreboard bench for na_chip_sequencer: stimulus pushes a per-cycle
// expected timeline, a negedge monitor pops and compares each snapshot.
module tb_na_chip_sequencer;

  localparam int PD = 2;
  localparam int ST = 3;
  localparam int LT = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       pump_rev;
  logic [7:0] mix_cycles;
  logic       busy, done, aborted;
  logic [3:0] step;
  logic       lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
  logic       loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
  logic       pump1, pump2, pump3;

  na_chip_sequencer #(
    .PUMP_DIV(PD),
    .SETTLE_TICKS(ST),
    .LOAD_TICKS(LT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pump_rev(pump_rev), .mix_cycles(mix_cycles),
    .busy(busy), .done(done), .aborted(aborted), .step(step),
    .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
    .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl),
    .loop_exit_ctl(loop_exit_ctl), .bead_vtl_ctl(bead_vtl_ctl),
    .bead_trap_ctl(bead_trap_ctl), .collection_ctl(collection_ctl),
    .waste_ctl(waste_ctl), .pump1(pump1), .pump2(pump2), .pump3(pump3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] step;
    logic [9:0] ctl;
    logic [2:0] pmp;
    logic       busy;
    logic       done;
    logic       ab;
  } exp_t;

  exp_t sbq[$];
  exp_t plan[$];
  int   pt;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Closed-line patterns, order {lysis,wash,elute,horiz,vertical,loop_exit,
  // bead_vtl,bead_trap,collection,waste}; index = step number.
  logic [9:0] mask [8] = '{10'b1111111111, 10'b1111110010, 10'b1110011111,
                           10'b0111011111, 10'b1111111111, 10'b1111101010,
                           10'b1011001010, 10'b1101001001};
  logic [2:0] fw [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  wire [9:0] ctl_vec = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                        loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl,
                        collection_ctl, waste_ctl};
  wire [2:0] pmp_vec = {pump1, pump2, pump3};

  always @(posedge clk) cyc <= cyc + 1;

  exp_t       mon_e;
  logic [9:0] prev_open = '0;
  logic [9:0] cur_open;

  // Monitor: compare the snapshot due this cycle and check break-before-make.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_open = '0;
    end else begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_assert++; n_fail++;
        $display("FAIL sb_skip: entry for cycle %0d not sampled, now %0d", sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        mon_e = sbq.pop_front();
        n_assert++;
        if ({step, ctl_vec, pmp_vec, busy, done, aborted} !==
            {mon_e.step, mon_e.ctl, mon_e.pmp, mon_e.busy, mon_e.done, mon_e.ab}) begin
          n_fail++;
          $display("FAIL snapshot cyc=%0d: got step=%0d ctl=%b pump=%b busy=%b done=%b aborted=%b, expected step=%0d ctl=%b pump=%b busy=%b done=%b aborted=%b",
                   cyc, step, ctl_vec, pmp_vec, busy, done, aborted,
                   mon_e.step, mon_e.ctl, mon_e.pmp, mon_e.busy, mon_e.done, mon_e.ab);
        end
      end
      cur_open = ~ctl_vec;
      if (prev_open != '0 && cur_open != '0) begin
        n_assert++;
        if (prev_open != cur_open) begin
          n_fail++;
          $display("FAIL break_before_make cyc=%0d: open %b follows open %b, required equal sets",
                   cyc, cur_open, prev_open);
        end
      end
      prev_open = cur_open;
    end
  end

  task automatic add(input int st, input logic [9:0] c, input logic [2:0] p,
                     input logic b, input logic d, input logic a);
    exp_t e;
    e.cyc = pt; e.step = 4'(st); e.ctl = c; e.pmp = p;
    e.busy = b; e.done = d; e.ab = a;
    plan.push_back(e);
    pt++;
  endtask

  task automatic push_idle(input int from, input int n);
    pt = from;
    plan.delete();
    for (int k = 0; k < n; k++) add(0, '1, 3'b111, 1'b0, 1'b0, 1'b0);
    foreach (plan[i]) sbq.push_back(plan[i]);
  endtask

  // Expected timeline for a run started in cycle c0; abort_at < 0 means none.
  task automatic build_run(input int c0, input int mix, input bit rev, input int abort_at);
    int ph;
    plan.delete();
    pt = c0 + 1;
    for (int s = 1; s <= 7; s++) begin
      if (s == 1 || s == 2 || s == 6) begin
        for (int k = 0; k < LT; k++) add(s, mask[s], 3'b111, 1'b1, 1'b0, 1'b0);
      end else begin
        for (int k = 0; k < mix * 6 * PD; k++) begin
          ph = (k / PD) % 6;
          add(s, mask[s], rev ? fw[5 - ph] : fw[ph], 1'b1, 1'b0, 1'b0);
        end
      end
      for (int k = 0; k < ST; k++) add(8, '1, 3'b111, 1'b1, 1'b0, 1'b0);
    end
    add(10, '1, 3'b111, 1'b1, 1'b1, 1'b0);
    add(0, '1, 3'b111, 1'b0, 1'b0, 1'b0);
    add(0, '1, 3'b111, 1'b0, 1'b0, 1'b0);
    if (abort_at >= 0) begin
      while (plan.size() > 0 && plan[plan.size() - 1].cyc > abort_at) void'(plan.pop_back());
      pt = abort_at + 1;
      for (int k = 0; k < ST; k++) add(9, '1, 3'b111, 1'b1, 1'b0, 1'b0);
      add(9, '1, 3'b111, 1'b1, 1'b0, 1'b1);
      add(0, '1, 3'b111, 1'b0, 1'b0, 1'b0);
      add(0, '1, 3'b111, 1'b0, 1'b0, 1'b0);
    end
    foreach (plan[i]) sbq.push_back(plan[i]);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbq.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL drain_timeout: %0d expected cycles unchecked, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_lines(input string name);
    n_assert++;
    if ({step, ctl_vec, pmp_vec, busy, done, aborted} !== {4'd0, 10'h3FF, 3'b111, 3'b000}) begin
      n_fail++;
      $display("FAIL %s: got step=%0d ctl=%b pump=%b busy=%b done=%b aborted=%b, expected step=0 ctl=1111111111 pump=111 busy=0 done=0 aborted=0",
               name, step, ctl_vec, pmp_vec, busy, done, aborted);
    end
  endtask

  // Launch a run in the current cycle and release start on the next edge.
  task automatic launch(input int mix, input bit rev, input bit with_abort,
                        input int abort_rel, output int c0);
    c0 = cyc;
    start = 1'b1; abort = with_abort; mix_cycles = 8'(mix); pump_rev = rev;
    build_run(c0, mix, rev, (abort_rel >= 0) ? c0 + abort_rel : -1);
    next_cycle();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic pulse_abort_at(input int c);
    at_cycle(c);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
  endtask

  initial begin
    int c0;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; pump_rev = 1'b0; mix_cycles = 8'd0;
    #1 rst_n = 1'b0;
    #1 check_reset_lines("reset_state");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    push_idle(cyc, 3);
    wait_drain(20);

    // Abort while idle is ignored.
    abort = 1'b1;
    push_idle(cyc + 1, 3);
    next_cycle();
    abort = 1'b0;
    wait_drain(20);

    // Full forward run; a mid-run start with new settings must change nothing.
    launch(1, 1'b0, 1'b0, -1, c0);
    at_cycle(c0 + 20);
    start = 1'b1; mix_cycles = 8'd3; pump_rev = 1'b1;
    next_cycle();
    start = 1'b0; mix_cycles = 8'd0; pump_rev = 1'b0;
    wait_drain(200);
    next_cycle();

    // Reverse pump direction.
    launch(1, 1'b1, 1'b0, -1, c0);
    wait_drain(200);
    next_cycle();

    // mix_cycles=0 skips pumped steps; abort during DONE is ignored.
    launch(0, 1'b0, 1'b0, -1, c0);
    pulse_abort_at(c0 + 34);
    wait_drain(200);
    next_cycle();

    // Abort during MIX.
    launch(1, 1'b0, 1'b0, 33, c0);
    pulse_abort_at(c0 + 33);
    wait_drain(200);
    next_cycle();

    // Start and abort together: run starts; abort on the last LOAD_BEADS clock wins.
    launch(1, 1'b0, 1'b1, 4, c0);
    pulse_abort_at(c0 + 4);
    wait_drain(200);
    next_cycle();

    // Abort during SETTLE, with two pump cycles requested.
    launch(2, 1'b0, 1'b0, 6, c0);
    pulse_abort_at(c0 + 6);
    wait_drain(200);
    next_cycle();

    // Asynchronous reset in the middle of LYSIS.
    launch(1, 1'b0, 1'b0, -1, c0);
    at_cycle(c0 + 16);
    #2;
    sbq.delete();
    rst_n = 1'b0;
    #1 check_reset_lines("async_reset_mid_lysis");
    next_cycle();
    check_reset_lines("reset_held");
    next_cycle();
    rst_n = 1'b1;
    push_idle(cyc, 3);
    wait_drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/na_chip_sequencer.md
Name: na_chip_sequencer

Overview:
- Clocked controller that drives the pneumatic control lines of the 10-lane nucleic-acid reactor chip.
- Lane count is fixed by the chip: every control line fans out to all lanes.
- Runs the fixed protocol LOAD_BEADS, LOAD_CELLS, LYSIS, MIX, CAPTURE, WASH, ELUTE and generates the 3-phase peristaltic pump pattern.
- Sits between the host/command logic and the solenoid-driver board; it is the driving end of the chip's valve-control interface.

Parameters:
- PUMP_DIV, 1000, clocks each pump phase is held (>=1)
- SETTLE_TICKS, 500, clocks of all-closed break-before-make between steps (>=1)
- LOAD_TICKS, 20000, clocks for each non-pumped step (LOAD_BEADS, LOAD_CELLS, WASH) (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; sampled in IDLE only
- abort  in  1  one-cycle request to stop any run in progress
- pump_rev  in  1  pump direction, latched at start (1 = reverse)
- mix_cycles  in  8  full pump cycles per pumped step, latched at start
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when the abort sequence ends
- step  out  4  current state encoding, for debug
- lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl  out  1 each  valve air lines (1 = pressurised = valve closed)
- pump1, pump2, pump3  out  1 each  pump valve air lines (1 = closed)

Behaviour:
- Reset (asynchronous, and at any time):
  - every *_ctl output and pump1..3 go to 1;
  - busy, done and aborted go to 0;
  - the state machine goes to IDLE and all counters clear.
- All outputs are registered. Valve lines change only on state entry or at a pump phase boundary.
- States: IDLE, LOAD_BEADS, LOAD_CELLS, LYSIS, MIX, CAPTURE, WASH, ELUTE, SETTLE, ABORT, DONE.
- Accepting a run: start in IDLE latches mix_cycles and pump_rev. The next cycle enters LOAD_BEADS with busy=1. start in any other state is ignored.
- Valves opened per step (each listed line = 0; every unlisted line = 1):
  - LOAD_BEADS: bead_vtl, bead_trap, waste
  - LOAD_CELLS: horiz, vertical
  - LYSIS: lysis, vertical
  - MIX: none (closed loop)
  - CAPTURE: loop_exit, bead_trap, waste
  - WASH: wash, vertical, loop_exit, bead_trap, waste
  - ELUTE: elute, vertical, loop_exit, bead_trap, collection
- Step durations:
  - LOAD_BEADS, LOAD_CELLS, WASH: exactly LOAD_TICKS clocks each.
  - LYSIS, MIX, CAPTURE, ELUTE (pumped steps): mix_cycles*6*PUMP_DIV clocks each.
  - mix_cycles=0: every pumped step is skipped and the machine goes straight to its SETTLE.
- Pump pattern:
  - Forward {pump1,pump2,pump3} sequence: 011, 001, 101, 100, 110, 010, repeating; each phase held PUMP_DIV clocks.
  - Reverse (pump_rev=1): same six phases in reverse order, starting at 010.
  - Every pumped step starts at phase 0.
  - Outside pumped steps the pump lines are 111.
- SETTLE:
  - Follows every step, including ELUTE.
  - All valves and pumps are 1 for SETTLE_TICKS clocks, then the machine enters the next step.
  - After ELUTE, SETTLE goes to DONE.
- DONE: held 1 cycle with done=1, then IDLE with busy=0 in the following cycle.
- Abort:
  - abort in any busy state, including SETTLE, goes to ABORT on the next cycle.
  - ABORT holds all lines at 1 for SETTLE_TICKS clocks, pulses aborted for 1 cycle, then enters IDLE.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start is accepted and abort is ignored.
  - abort in the same cycle a step ends: abort wins.
  - abort during DONE is ignored.
- Counters:
  - tick counter width = clog2 of max(PUMP_DIV, SETTLE_TICKS, LOAD_TICKS) + 1;
  - 3-bit phase counter, wraps 5->0;
  - 8-bit cycle counter compared against the latched mix_cycles.
  - Inputs changing mid-run have no effect.

Decomposition:
- Package na_ctrl_pkg holds:
  - the state enum;
  - the valve-vector index constants (10 lines);
  - per-step open-mask constants;
  - the 6-entry pump phase table.
- One sub-module, peristaltic_phase_gen: enable, dir, PUMP_DIV → pump[2:0] and a cycle_done pulse.

Test Plan (PUMP_DIV=2, SETTLE_TICKS=3, LOAD_TICKS=4 unless stated):
- Reset mid-run: assert rst_n=0 during LYSIS → all 13 lines = 1, busy=0 in the same cycle, without waiting for a clock edge.
- Full run: start at cycle 0 with mix_cycles=1, forward pump.
  - busy=1 from cycle 1; LOAD_BEADS occupies cycles 1-4.
  - done pulses at cycle 82 (60 step clocks + 21 settle clocks + 1).
  - busy=0 at cycle 83.
- Pump waveform in LYSIS with mix_cycles=1: pumps go 011,011,001,001,101,101,100,100,110,110,010,010, then 111.
  - With pump_rev=1 the sequence is reversed, starting 010,010.
- mix_cycles=0: only LOAD_BEADS, LOAD_CELLS and WASH execute; done at cycle 1+12+21 = 34.
- Abort during MIX: all lines = 1 the next cycle; aborted pulses after 3 clocks; IDLE; no done pulse.
- Simultaneous start and abort in IDLE: run starts. A start pulse mid-run is ignored (step sequence unchanged). Break-before-make check: no cycle has two different steps' open valves at 0 simultaneously.
